// File: rtl/npu_pkg.sv
// npu_pkg: shared NPU constants, reader FSM encoding and requantisation helper.
// Build macro CONV1_RDR_ROUND_EN adds round-half-up before the shift.
package npu_pkg;

    localparam int OUT_H = 14;
    localparam int OUT_W = 13;
    localparam int CHAN  = 10;
    localparam int ACC_W = 24;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } rdr_state_t;

    // ReLU on the raw accumulator, then shift and clamp to 8 bits.
    function automatic logic [7:0] requant(
        input logic signed [ACC_W-1:0] acc,
        input int                      shift
    );
        logic signed [ACC_W:0] t;
        t = {acc[ACC_W-1], acc};
`ifdef CONV1_RDR_ROUND_EN
        t = t + ((ACC_W+1)'(1) << (shift - 1));
`endif
        t = t >>> shift;
        if (acc[ACC_W-1])
            return 8'd0;
        else if (t > (ACC_W+1)'(255))
            return 8'd255;
        else
            return t[7:0];
    endfunction

endpackage

// File: rtl/requant_unit.sv
// requant_unit: combinational ReLU / shift / saturate of one accumulator.
// Rounding follows CONV1_RDR_ROUND_EN through npu_pkg::requant.
module requant_unit #(
    parameter int SHIFT = 8
) (
    input  logic signed [npu_pkg::ACC_W-1:0] acc,
    output logic        [7:0]                px
);
    import npu_pkg::*;

    assign px = requant(acc, SHIFT);

endmodule

// File: rtl/conv1_fmap_reader.sv
// conv1_fmap_reader: captures conv1 accumulator maps and streams requantised
// pixels in raster order. CONV1_RDR_ROUND_EN enables round-half-up.
module conv1_fmap_reader #(
    parameter int OUT_H = npu_pkg::OUT_H,
    parameter int OUT_W = npu_pkg::OUT_W,
    parameter int CHAN  = npu_pkg::CHAN,
    parameter int ACC_W = npu_pkg::ACC_W,
    parameter int SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [3:0]              in_chan,
    input  logic signed [ACC_W-1:0] in_buff [OUT_H][OUT_W],
    output logic                    busy,
    output logic                    px_valid,
    input  logic                    px_ready,
    output logic [7:0]              px_data,
    output logic [3:0]              px_chan,
    output logic [3:0]              px_row,
    output logic [3:0]              px_col,
    output logic                    px_last,
    output logic                    frame_done,
    output logic                    overflow
);
    import npu_pkg::*;

    rdr_state_t state_q, state_d;

    logic signed [ACC_W-1:0] cap_q [OUT_H][OUT_W];
    logic [3:0] row_q, col_q, chan_q;
    logic [7:0] q_px;
    logic       xfer, last_xfer, capture;

    assign xfer      = px_valid && px_ready;
    assign last_xfer = xfer && px_last;
    // A map arriving on the final beat chains straight into the next stream.
    assign capture   = in_valid && (state_q == S_IDLE || last_xfer);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (in_valid) state_d = S_SEND;
            S_SEND: if (last_xfer && !in_valid) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        px_valid = 1'b0;
        px_last  = 1'b0;
        px_data  = 8'd0;
        if (state_q == S_SEND) begin
            busy     = 1'b1;
            px_valid = 1'b1;
            px_last  = row_q == 4'(OUT_H-1) && col_q == 4'(OUT_W-1);
            px_data  = q_px;
        end
    end

    assign px_chan = chan_q;
    assign px_row  = row_q;
    assign px_col  = col_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= 4'd0;
            col_q      <= 4'd0;
            chan_q     <= 4'd0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= last_xfer && chan_q == 4'(CHAN-1);
            if (in_valid && !capture)
                overflow <= 1'b1;
            if (capture) begin
                chan_q <= in_chan;
                row_q  <= 4'd0;
                col_q  <= 4'd0;
            end else if (xfer) begin
                if (col_q == 4'(OUT_W-1)) begin
                    col_q <= 4'd0;
                    row_q <= row_q + 4'd1;
                end else begin
                    col_q <= col_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture)
            cap_q <= in_buff;
    end

    requant_unit #(
        .SHIFT (SHIFT)
    ) u_requant (
        .acc (cap_q[row_q][col_q]),
        .px  (q_px)
    );

endmodule

// File: tb/tb_conv1_fmap_reader.sv
// tb_conv1_fmap_reader: randomized maps checked against a beat-queue model.
// Model rounding follows CONV1_RDR_ROUND_EN like the design.
module tb_conv1_fmap_reader;

    localparam int H   = 14;
    localparam int W   = 13;
    localparam int NCH = 10;
    localparam int AW  = 24;
    localparam int SH  = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [3:0] ch;
        logic [3:0] r;
        logic [3:0] c;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic px_ready = 1'b0;
    logic [3:0] in_chan = 4'd0;
    logic signed [AW-1:0] in_buff [H][W];
    logic busy, px_valid, px_last, frame_done, overflow;
    logic [7:0] px_data;
    logic [3:0] px_chan, px_row, px_col;

    beat_t exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int fd_cnt = 0;
    bit exp_ovf = 1'b0;

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_cnt++;

    conv1_fmap_reader #(
        .OUT_H (H), .OUT_W (W), .CHAN (NCH), .ACC_W (AW), .SHIFT (SH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_chan    (in_chan),
        .in_buff    (in_buff),
        .busy       (busy),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .px_chan    (px_chan),
        .px_row     (px_row),
        .px_col     (px_col),
        .px_last    (px_last),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] ref_q(input longint a);
        longint t;
        if (a < 0) return 8'd0;
`ifdef CONV1_RDR_ROUND_EN
        t = (a + (longint'(1) << (SH - 1))) / (longint'(1) << SH);
`else
        t = a / (longint'(1) << SH);
`endif
        return (t > 255) ? 8'd255 : 8'(t);
    endfunction

    // Fill in_buff with a pattern; queue the expected beats if it will be taken.
    task automatic load(input int pat, input logic [3:0] ch, input bit push);
        logic signed [AW-1:0] rv;
        longint v;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (pat == 0) begin
                    v = longint'(r * W + c) << SH;
                end else begin
                    case ($urandom_range(0, 2))
                        0: begin rv = AW'($urandom); v = rv; end
                        1: v = longint'($urandom_range(0, 300 * 256));
                        default: v = -longint'($urandom_range(1, 5000));
                    endcase
                end
                if (pat == 1 && r == 0) begin
                    case (c)
                        0: v = -5;
                        1: v = 64'h7FFFFF;
                        2: v = 255 << 8;
                        3: v = 256 << 8;
                        4: v = 64'h180;
                        5: v = 64'h17F;
                        default: ;
                    endcase
                end
                in_buff[r][c] = AW'(v);
                if (push)
                    exp_q.push_back('{ref_q(v), ch, 4'(r), 4'(c),
                                      (r == H - 1 && c == W - 1)});
            end
        end
    endtask

    task automatic start(input int pat, input logic [3:0] ch);
        @(negedge clk);
        load(pat, ch, 1'b1);
        in_valid = 1'b1;
        in_chan  = ch;
    endtask

    // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: random ready.
    task automatic drain(input int mode, input int inj_at, input logic [3:0] inj_ch,
                         input int rst_at, input int exp_n);
        int n = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        bit did_rst = 1'b0;
        beat_t held, cur;
        held = '0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            in_valid = 1'b0;
            cur = '{px_data, px_chan, px_row, px_col, px_last};
            if (stalled) chk("hold", cur, held);
            chk("px_valid", px_valid, 1'b1);
            if (!px_valid || cyc > 3000) begin
                chk("stream_timeout", cyc, 0);
                exp_q.delete();
                break;
            end
            case (mode)
                0: px_ready = 1'b1;
                1: px_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: px_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            if (px_ready && n == rst_at) begin
                rst = 1'b1;
                px_ready = 1'b0;
                did_rst = 1'b1;
                exp_q.delete();
                break;
            end
            stalled = !px_ready;
            held = cur;
            if (px_ready) begin
                chk($sformatf("beat%0d", n), cur, exp_q.pop_front());
                if (n == inj_at) begin
                    if (exp_q.size() != 0) exp_ovf = 1'b1;
                    load(2, inj_ch, exp_q.size() == 0);
                    in_valid = 1'b1;
                    in_chan  = inj_ch;
                end
                n++;
            end
        end
        chk("beat_count", n, exp_n);
        @(negedge clk);
        if (did_rst) begin
            exp_ovf = 1'b0;
            chk("rst_px_valid", px_valid, 1'b0);
            chk("rst_overflow", overflow, 1'b0);
            chk("rst_busy", busy, 1'b0);
            rst = 1'b0;
        end else begin
            chk("idle_px_valid", px_valid, 1'b0);
        end
        chk("overflow", overflow, exp_ovf);
        @(negedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_px_valid", px_valid, 1'b0);
        chk("reset_px_last", px_last, 1'b0);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_overflow", overflow, 1'b0);
        chk("reset_px_data", px_data, 8'd0);
        chk("reset_pos", {px_chan, px_row, px_col}, 12'd0);
        rst = 1'b0;

        start(0, 4'd3);
        drain(0, -1, 4'd0, -1, H * W);
        chk("fd_after_ch3", fd_cnt, 0);

        start(1, 4'd5);
        drain(0, -1, 4'd0, -1, H * W);

        start(2, 4'd2);
        drain(1, -1, 4'd0, -1, H * W);

        start(2, 4'd8);
        drain(2, H * W - 1, 4'd9, -1, 2 * H * W);
        chk("fd_after_b2b", fd_cnt, 1);

        start(2, 4'd12);
        drain(2, 50, 4'd9, -1, H * W);
        chk("fd_after_drop", fd_cnt, 1);

        start(2, 4'd9);
        drain(0, -1, 4'd0, 100, 100);
        chk("fd_after_rst", fd_cnt, 1);

        start(1, 4'd9);
        drain(2, -1, 4'd0, -1, H * W);
        chk("fd_after_ch9", fd_cnt, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
